// File: rtl/gray_cnt_arbiter.sv
// Two-requester round-robin sequencer for a shared Gray-code counter.
// Grants one burst at a time, drives the counter enable, and checks every returned code.
module gray_cnt_arbiter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic             cnt_en,
  input  logic [WIDTH-1:0] gray_in,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] start_code,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               chk_v_q;
  logic               cnt_en_q, busy_q, done_q, done_id_q;

  logic [1:0]             req_v;
  logic [1:0][LEN_W-1:0]  req_len;
  logic                   gnt_v, gnt_id, accept;
  logic [LEN_W-1:0]       acc_len;

  assign req_v   = {req1_valid, req0_valid};
  assign req_len = {req1_len, req0_len};

  // On a tie the requester that did not own the previous burst wins.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (req_v == 2'b11) begin
      gnt_v  = 1'b1;
      gnt_id = ~last_q;
    end else if (req_v[0]) begin
      gnt_v  = 1'b1;
      gnt_id = 1'b0;
    end else if (req_v[1]) begin
      gnt_v  = 1'b1;
      gnt_id = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && !rst && gnt_v;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign acc_len    = req_len[gnt_id];

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    shadow_d = shadow_q;
    start_d  = start_q;
    id_d     = id_q;
    last_d   = last_q;
    err_d    = err_q | (chk_v_q && (gray_in != bin2gray(shadow_q)));
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d     = gnt_id;
          last_d   = gnt_id;
          start_d  = gray_in;
          shadow_d = gray2bin(gray_in);
          remain_d = acc_len;
          state_d  = (acc_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        shadow_d = shadow_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_W'(1)) state_d = CHECK;
      end
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      shadow_q  <= '0;
      start_q   <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      chk_v_q   <= 1'b0;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      shadow_q  <= shadow_d;
      start_q   <= start_d;
      id_q      <= id_d;
      last_q    <= last_d;
      err_q     <= err_d;
      chk_v_q   <= cnt_en_q;
      cnt_en_q  <= (state_d == RUN);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      done_id_q <= (state_d == DONE) ? id_d : 1'b0;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign start_code = start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gray_cnt_arbiter.sv
// Randomized scoreboard bench for gray_cnt_arbiter with a behavioural Gray counter.
module tb_gray_cnt_arbiter;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [LEN_W-1:0] req0_len, req1_len;
  logic cnt_en, busy, done, done_id, err;
  logic [WIDTH-1:0] gray_in, start_code;

  always #5 clk = ~clk;

  gray_cnt_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
    .cnt_en(cnt_en), .gray_in(gray_in), .busy(busy), .done(done),
    .done_id(done_id), .start_code(start_code), .err(err)
  );

  // Counter device: binary count exposed as Gray, with preload and one-shot skip.
  logic [WIDTH-1:0] cbin = '0;
  int               cyc = 0;
  logic             preload_v = 1'b0;
  logic [WIDTH-1:0] preload_val = '0;
  bit               inject = 1'b0;
  int               skip_cyc = -1;

  assign gray_in = cbin ^ (cbin >> 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload_v) cbin <= preload_val;
    else if (cnt_en && cyc != skip_cyc) cbin <= cbin + 8'd1;
  end

  typedef struct {
    bit               id;
    logic [WIDTH-1:0] sc;
    int               dcyc;
    logic [WIDTH-1:0] endb;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int checks = 0, errors = 0;
  int idle_at = 0, run_lo = 1, run_hi = 0, err_at = NEVER;
  bit last_m = 1'b1;
  bit g0, g1, idle_m;
  logic [LEN_W-1:0] len_m;
  int tmo_n = 0, tmo_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Model and monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tmo_n != tmo_seen) begin
      tmo_seen = tmo_n;
      chk("stim_timeout", 32'd1, 32'd0);
    end
    if (rst) begin
      q.delete();
      idle_at = 0; run_lo = 1; run_hi = 0; err_at = NEVER; last_m = 1'b1; skip_cyc = -1;
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_err", err, 0);
      chk("rst_start_code", start_code, 0);
    end else begin
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e_m = q.pop_front();
          chk("done_id", done_id, e_m.id);
          chk("done_cycle", cyc, e_m.dcyc);
          chk("start_code", start_code, e_m.sc);
          chk("advance_count", cbin, e_m.endb);
        end
      end else if (q.size() != 0 && cyc > q[0].dcyc) begin
        chk("missing_done", 32'd0, 32'd1);
        void'(q.pop_front());
      end

      chk("cnt_en", cnt_en, (cyc >= run_lo && cyc <= run_hi));
      chk("busy", busy, (cyc < idle_at));
      chk("err", err, (cyc >= err_at));

      idle_m = (cyc >= idle_at);
      g0 = idle_m && req0_valid && (!req1_valid || last_m);
      g1 = idle_m && req1_valid && (!req0_valid || !last_m);
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);

      if (g0 || g1) begin
        len_m     = g1 ? req1_len : req0_len;
        e_m.id    = g1;
        e_m.sc    = cbin ^ (cbin >> 1);
        e_m.dcyc  = cyc + ((len_m == 0) ? 1 : int'(len_m) + 2);
        e_m.endb  = cbin + len_m;
        run_lo    = cyc + 1;
        run_hi    = cyc + int'(len_m);
        idle_at   = e_m.dcyc + 1;
        last_m    = g1;
        if (inject && len_m != 0) begin
          skip_cyc = cyc + 1;
          e_m.endb = e_m.endb - 8'd1;
          if (err_at > cyc + 3) err_at = cyc + 3;
        end
        q.push_back(e_m);
      end
    end
  end

  task automatic drive(input bit v0, input logic [7:0] l0, input bit v1, input logic [7:0] l1,
                       input int ngr);
    int got = 0;
    int t = 0;
    bit h0, h1;
    req0_valid = v0; req0_len = l0; req1_valid = v1; req1_len = l1;
    while (got < ngr && t < 400) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      t++;
      if (h0) got++;
      if (h1) got++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (got < ngr) tmo_n++;
  endtask

  task automatic idle_wait();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) tmo_n++;
    @(posedge clk); #1;
  endtask

  initial begin
    bit h0, h1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_len = '0; req1_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    drive(1, 5, 0, 0, 1); idle_wait();
    drive(0, 0, 1, 0, 1); idle_wait();          // zero length from requester 1
    drive(1, 3, 1, 3, 4); idle_wait();          // held contention: 0,1,0,1

    preload_val = 8'd254; preload_v = 1'b1;
    @(posedge clk); #1 preload_v = 1'b0;
    drive(1, 4, 0, 0, 1); idle_wait();          // wrap through 255 -> 0

    inject = 1'b1;
    drive(1, 4, 0, 0, 1);
    inject = 1'b0;
    idle_wait();
    drive(1, 2, 1, 3, 2); idle_wait();          // err must stay set

    drive(1, 10, 0, 0, 1);
    @(posedge clk); #2 rst = 1'b1;              // mid-burst, between edges
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 2, 1, 2, 1); idle_wait();          // tie after reset goes to requester 0

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1;
        req0_len   = 8'($urandom_range(0, 12));
      end
      if (h1) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1;
        req1_len   = 8'($urandom_range(0, 12));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle_wait();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
